// File: rtl/sdp_ram_burst_reader_if.sv
// Request, RAM read port B and output stream of the burst reader, bundled for port hookup.
// master = requester/RAM/sink environment, slave = the reader itself.
interface sdp_ram_burst_reader_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W:0]   req_len;
  logic [ADDR_W-1:0] ram_addrb;
  logic [DATA_W-1:0] ram_doutb;
  logic              dout_valid;
  logic              dout_ready;
  logic [DATA_W-1:0] dout_data;
  logic              dout_last;
  logic              busy;

  modport master (
    output req_valid, req_addr, req_len, ram_doutb, dout_ready,
    input  req_ready, ram_addrb, dout_valid, dout_data, dout_last, busy
  );

  modport slave (
    input  req_valid, req_addr, req_len, ram_doutb, dout_ready,
    output req_ready, ram_addrb, dout_valid, dout_data, dout_last, busy
  );
endinterface

// File: rtl/sdp_ram_burst_reader.sv
// Burst read controller for a 1-cycle-latency RAM read port: issues addresses under a
// credit limit so the small output FIFO can never overflow, streaming words with a last tag.
module sdp_ram_burst_reader #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  sdp_ram_burst_reader_if.slave bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int CR_W  = CNT_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] ptr, addr_hold;
  logic [ADDR_W:0]   remaining;
  logic              inflight, inflight_last;
  beat_t             fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  fifo_count;
  logic [CR_W-1:0]   credit_used;
  logic              accept, issue, push, pop;

  assign accept = (state == S_IDLE) && bus.req_valid && (bus.req_len != '0);
  assign pop    = bus.dout_valid && bus.dout_ready;
  assign push   = inflight;

  // Words buffered plus the one in the RAM pipeline, less the one leaving this cycle,
  // must stay below the FIFO depth; this is what makes the blind push safe.
  assign credit_used = CR_W'(fifo_count) + CR_W'(inflight);
  assign issue = (state == S_ISSUE) && (credit_used < CR_W'(FIFO_DEPTH) + CR_W'(pop));

  assign bus.ram_addrb  = issue ? ptr : addr_hold;
  assign bus.req_ready  = (state == S_IDLE);
  assign bus.busy       = (state != S_IDLE);
  assign bus.dout_valid = (fifo_count != '0);
  assign bus.dout_data  = fifo_q[rd_ptr].data;
  assign bus.dout_last  = fifo_q[rd_ptr].last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (accept) state_n = S_ISSUE;
      S_ISSUE: if (issue && remaining == (ADDR_W+1)'(1)) state_n = S_DRAIN;
      S_DRAIN: if (pop && bus.dout_last) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr           <= '0;
      remaining     <= '0;
      addr_hold     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue && (remaining == (ADDR_W+1)'(1));
      if (accept) begin
        ptr       <= bus.req_addr;
        remaining <= bus.req_len;
      end else if (issue) begin
        ptr       <= ptr + 1'b1;
        remaining <= remaining - 1'b1;
        addr_hold <= ptr;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= '{last: inflight_last, data: bus.ram_doutb};
        wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
    end
  end
endmodule

// File: tb/tb_sdp_ram_burst_reader.sv
// Directed bench for sdp_ram_burst_reader with a RAM model (mem[i]=A5000000|i) and a
// scoreboard queue of expected {last,data} beats filled at request time.
module tb_sdp_ram_burst_reader;
  logic clk = 1'b0;
  logic reset;
  int   n_pass = 0;
  int   n_total = 0;
  int   nbeats = 0;

  logic [31:0] mem [512];
  logic [32:0] sb [$];
  logic        stall_q = 1'b0;
  logic [32:0] held_q = '0;

  sdp_ram_burst_reader_if #(.ADDR_W(9), .DATA_W(32)) bus ();

  sdp_ram_burst_reader #(.ADDR_W(9), .DATA_W(32), .FIFO_DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.ram_doutb <= mem[bus.ram_addrb];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Stream monitor: scoreboard compare on every handshake, stability while stalled.
  always @(negedge clk) begin
    if (reset) begin
      stall_q <= 1'b0;
    end else begin
      if (stall_q) begin
        check("stall_valid", bus.dout_valid, 1);
        check("stall_beat", {bus.dout_last, bus.dout_data}, held_q);
      end
      if (bus.dout_valid && bus.dout_ready) begin
        check("beat_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          logic [32:0] e;
          e = sb.pop_front();
          check("beat_data", bus.dout_data, e[31:0]);
          check("beat_last", bus.dout_last, e[32]);
        end
        nbeats <= nbeats + 1;
      end
      stall_q <= bus.dout_valid && !bus.dout_ready;
      held_q  <= {bus.dout_last, bus.dout_data};
    end
  end

  task automatic push_exp(input logic [8:0] addr, input int len);
    for (int i = 0; i < len; i++) begin
      logic [8:0] a;
      a = addr + 9'(i);
      sb.push_back({(i == len - 1), 32'hA500_0000 | {23'd0, a}});
    end
  endtask

  task automatic send(input logic [8:0] addr, input int len);
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_len   = 10'(len);
    push_exp(addr, len);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((sb.size() != 0 || !bus.req_ready) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, (sb.size() == 0) && bus.req_ready, 1);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'hA500_0000 | i;
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_len    = '0;
    bus.dout_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_ram_addrb", bus.ram_addrb, 0);
    check("rst_dout_valid", bus.dout_valid, 0);
    check("rst_dout_data", bus.dout_data, 0);
    check("rst_dout_last", bus.dout_last, 0);
    check("rst_busy", bus.busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Normal burst, cycle-exact: accept in A
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 9'h010;
    bus.req_len   = 10'd4;
    push_exp(9'h010, 4);
    @(negedge clk);
    check("acc_req_ready", bus.req_ready, 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k <= 4) check("norm_addrb", bus.ram_addrb, 9'h010 + 9'(k - 1));
      check("norm_valid", bus.dout_valid, (k >= 3));
      check("norm_last", bus.dout_last, (k == 6));
      check("norm_busy", bus.busy, 1);
      @(posedge clk); #1;
    end
    check("norm_ready_A7", bus.req_ready, 1);
    check("norm_busy_A7", bus.busy, 0);
    check("norm_sb_empty", sb.size(), 0);

    // Address wrap
    send(9'h1FE, 4);
    wait_idle("wrap_done", 40);

    // Backpressure: 10 stalled cycles then 1010...
    bus.dout_ready = 1'b0;
    send(9'h020, 8);
    repeat (9) begin @(posedge clk); #1; end
    for (int i = 0; i < 60 && (sb.size() != 0 || !bus.req_ready); i++) begin
      bus.dout_ready = ~bus.dout_ready;
      @(posedge clk); #1;
    end
    bus.dout_ready = 1'b1;
    wait_idle("bp_done", 10);

    // Zero length
    send(9'h055, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("zl_valid", bus.dout_valid, 0);
      check("zl_busy", bus.busy, 0);
      check("zl_ready", bus.req_ready, 1);
    end

    // Full memory, no bubbles after the first beat
    send(9'h100, 512);
    begin
      int w = 0;
      @(negedge clk);
      while (!bus.dout_valid && w < 20) begin @(negedge clk); w++; end
      check("full_first", bus.dout_valid, 1);
      for (int i = 1; i < 512; i++) begin
        @(negedge clk);
        check("full_nobubble", bus.dout_valid, 1);
      end
    end
    wait_idle("full_done", 20);

    // Reset mid-burst after third beat
    begin
      int base, n;
      base = nbeats;
      n = 0;
      send(9'h000, 16);
      while (nbeats < base + 3 && n < 30) begin @(posedge clk); #2; n++; end
      check("mid_reached_beat3", nbeats >= base + 3, 1);
      reset = 1'b1;
      sb.delete();
      #1;
      check("mid_valid", bus.dout_valid, 0);
      check("mid_ready", bus.req_ready, 1);
      check("mid_busy", bus.busy, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("post_valid", bus.dout_valid, 0);
      check("post_ready", bus.req_ready, 1);
    end
    send(9'h000, 2);
    wait_idle("post_done", 20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
